// File: rtl/operand_collect_stage.sv
// Operand collect stage: holds one issued instruction, resolves rs/rt per byte lane
// from forwarding sources, write-back and register file, and interlocks on blocked producers.
module operand_collect_stage #(
    parameter int unsigned PAY_WD = 64,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned NFWD   = 3,
    parameter int unsigned FWD_EN = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    output logic                          in_allowin,
    input  logic [PAY_WD-1:0]             in_pay,
    input  logic [4:0]                    in_rs,
    input  logic [4:0]                    in_rt,
    input  logic                          in_use_rs,
    input  logic                          in_use_rt,
    output logic                          out_valid,
    input  logic                          out_allowin,
    output logic [PAY_WD-1:0]             out_pay,
    output logic [DATA_W-1:0]             rs_value,
    output logic [DATA_W-1:0]             rt_value,
    output logic [4:0]                    rf_raddr1,
    output logic [4:0]                    rf_raddr2,
    input  logic [DATA_W-1:0]             rf_rdata1,
    input  logic [DATA_W-1:0]             rf_rdata2,
    input  logic [DATA_W/8-1:0]           wb_we,
    input  logic [4:0]                    wb_dest,
    input  logic [DATA_W-1:0]             wb_data,
    input  logic [NFWD*(DATA_W/8)-1:0]    fwd_we,
    input  logic [NFWD*5-1:0]             fwd_dest,
    input  logic [NFWD*DATA_W-1:0]        fwd_data,
    input  logic [NFWD-1:0]               fwd_blk,
    input  logic                          flush,
    output logic [15:0]                   stall_cnt
);

    localparam int unsigned BYTES = DATA_W / 8;

    logic              valid;
    logic [PAY_WD-1:0] pay_q;
    logic [4:0]        rs_q;
    logic [4:0]        rt_q;
    logic              use_rs_q;
    logic              use_rt_q;

    logic [DATA_W-1:0] opnd [2];
    logic [1:0]        hazard;
    logic              ready_go;
    logic              load;

    // Per-source lane resolution and hazard detection (p=0: rs, p=1: rt).
    always_comb begin : resolve
        logic [4:0]        src;
        logic              used;
        logic [DATA_W-1:0] rf_data;
        logic [7:0]        lane;
        logic              covered;
        logic [4:0]        dest;
        logic [BYTES-1:0]  we;

        opnd    = '{default: '0};
        hazard  = '0;
        src     = '0;
        used    = 1'b0;
        rf_data = '0;
        lane    = '0;
        covered = 1'b0;
        dest    = '0;
        we      = '0;

        for (int p = 0; p < 2; p++) begin
            src     = (p == 0) ? rs_q : rt_q;
            used    = (p == 0) ? use_rs_q : use_rt_q;
            rf_data = (p == 0) ? rf_rdata1 : rf_rdata2;

            for (int b = 0; b < int'(BYTES); b++) begin
                lane = rf_data[b*8 +: 8];
                if (wb_we[b] && wb_dest == src)
                    lane = wb_data[b*8 +: 8];
                // Walk oldest to youngest so the youngest matching source wins.
                if (FWD_EN != 0) begin
                    for (int i = int'(NFWD) - 1; i >= 0; i--) begin
                        if (fwd_we[i*int'(BYTES) + b] && fwd_dest[i*5 +: 5] == src)
                            lane = fwd_data[i*int'(DATA_W) + b*8 +: 8];
                    end
                end
                opnd[p][b*8 +: 8] = (src == 5'd0) ? 8'd0 : lane;
            end

            // A blocked producer is harmless once a younger source fully rewrites the register.
            covered = 1'b0;
            for (int i = 0; i < int'(NFWD); i++) begin
                dest = fwd_dest[i*5 +: 5];
                we   = fwd_we[i*int'(BYTES) +: BYTES];
                if (dest == src) begin
                    if (fwd_blk[i] && !covered)
                        hazard[p] = 1'b1;
                    if (FWD_EN == 0 && (|we))
                        hazard[p] = 1'b1;
                    if (&we)
                        covered = 1'b1;
                end
            end
            if (!used || src == 5'd0)
                hazard[p] = 1'b0;
        end
    end

    assign ready_go   = ~|hazard;
    assign in_allowin = reset || !valid || flush || (ready_go && out_allowin);
    assign out_valid  = valid && ready_go && !flush && !reset;
    assign load       = in_valid && in_allowin;

    assign out_pay   = pay_q;
    assign rf_raddr1 = rs_q;
    assign rf_raddr2 = rt_q;
    assign rs_value  = opnd[0];
    assign rt_value  = opnd[1];

    // Entry valid bit and saturating stall counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid     <= 1'b0;
            stall_cnt <= 16'd0;
        end else begin
            if (load)
                valid <= 1'b1;
            else if (flush || (ready_go && out_allowin))
                valid <= 1'b0;
            if (valid && !ready_go && stall_cnt != 16'hFFFF)
                stall_cnt <= stall_cnt + 16'd1;
        end
    end

    // Held payload and source fields carry no reset.
    always_ff @(posedge clk) begin
        if (load) begin
            pay_q    <= in_pay;
            rs_q     <= in_rs;
            rt_q     <= in_rt;
            use_rs_q <= in_use_rs;
            use_rt_q <= in_use_rt;
        end
    end

endmodule
